// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I control FSM with memory handshake watchdog
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic [2:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       mem_req,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       retire,
  output logic       trap,
  output logic       trap_cause,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_UTYPE    = 4'd12,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);

  // Static per-state controls; fetch/branch/mem_write flags gate the handshake-qualified strobes.
  typedef struct packed {
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       adr_src;
    logic       mem_req;
    logic       mem_write;
    logic       reg_write;
    logic       pc_write;
    logic       retire;
    logic       fetch;
    logic       branch;
    logic       trap;
  } ctrl_t;

  state_t           state;
  state_t           state_n;
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             trap_cause_q;
  logic             trap_cause_n;
  logic             wait_expired;

  function automatic ctrl_t decode_ctrl(input state_t s, input logic op5);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req    = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
        c.fetch      = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        c.adr_src = 1'b1;
        c.mem_req = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
        c.retire     = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      S_EXECI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.retire    = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
        c.branch    = 1'b1;
        c.retire    = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_write  = 1'b1;
      end
      S_UTYPE: begin
        // lui adds to zero, auipc adds to the instruction's own PC
        c.alu_src_a = op5 ? 2'b11 : 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_TRAP:  c.trap = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  assign wait_expired = (wait_cnt == TIMEOUT);

  always_comb begin
    state_n      = state;
    trap_cause_n = trap_cause_q;
    case (state)
      S_RESET: state_n = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          state_n = S_DECODE;
        end else if (wait_expired) begin
          state_n      = S_TRAP;
          trap_cause_n = 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_n = S_MEMADR;
          OP_RTYPE:          state_n = S_EXECR;
          OP_ITYPE:          state_n = S_EXECI;
          OP_BRANCH:         state_n = S_BRANCH;
          OP_JAL:            state_n = S_JAL;
          OP_LUI, OP_AUIPC:  state_n = S_UTYPE;
          default: begin
            state_n      = S_TRAP;
            trap_cause_n = 1'b0;
          end
        endcase
      end
      S_MEMADR: state_n = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (mem_ready) begin
          state_n = S_MEMWB;
        end else if (wait_expired) begin
          state_n      = S_TRAP;
          trap_cause_n = 1'b1;
        end
      end
      S_MEMWRITE: begin
        if (mem_ready) begin
          state_n = S_FETCH;
        end else if (wait_expired) begin
          state_n      = S_TRAP;
          trap_cause_n = 1'b1;
        end
      end
      S_MEMWB, S_ALUWB, S_BRANCH:       state_n = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_UTYPE: state_n = S_ALUWB;
      S_TRAP:                           state_n = S_TRAP;
      default: begin
        state_n      = S_TRAP;
        trap_cause_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_RESET;
      ctrl_q       <= '0;
      wait_cnt     <= '0;
      trap_cause_q <= 1'b0;
    end else begin
      state        <= state_n;
      ctrl_q       <= decode_ctrl(state_n, opcode[5]);
      trap_cause_q <= trap_cause_n;
      if (state_n != state) begin
        wait_cnt <= '0;
      end else if (ctrl_q.mem_req && !mem_ready && !wait_expired) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    case (opcode)
      OP_LOAD, OP_ITYPE: imm_src = 3'b000;
      OP_STORE:          imm_src = 3'b001;
      OP_LUI, OP_AUIPC:  imm_src = 3'b010;
      OP_BRANCH:         imm_src = 3'b101;
      OP_JAL:            imm_src = 3'b110;
      default:           imm_src = 3'b000;
    endcase
  end

  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign alu_op     = ctrl_q.alu_op;
  assign result_src = ctrl_q.result_src;
  assign adr_src    = ctrl_q.adr_src;
  assign mem_req    = ctrl_q.mem_req;
  assign mem_write  = ctrl_q.mem_write;
  assign reg_write  = ctrl_q.reg_write;
  assign ir_write   = ctrl_q.fetch & mem_ready;
  assign pc_write   = ctrl_q.pc_write | (ctrl_q.fetch & mem_ready) | (ctrl_q.branch & branch_taken);
  assign retire     = ctrl_q.retire | (ctrl_q.mem_write & mem_ready);
  assign trap       = ctrl_q.trap;
  assign trap_cause = trap_cause_q;
  assign state_dbg  = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;

  localparam int TO = 4;

  localparam logic [3:0] S_RESET    = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEMADR   = 4'd3;
  localparam logic [3:0] S_MEMREAD  = 4'd4;
  localparam logic [3:0] S_MEMWB    = 4'd5;
  localparam logic [3:0] S_MEMWRITE = 4'd6;
  localparam logic [3:0] S_EXECR    = 4'd7;
  localparam logic [3:0] S_EXECI    = 4'd8;
  localparam logic [3:0] S_ALUWB    = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JAL      = 4'd11;
  localparam logic [3:0] S_UTYPE    = 4'd12;
  localparam logic [3:0] S_TRAP     = 4'd15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'h00;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic [2:0] imm_src;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic       adr_src, mem_req, mem_write, ir_write, pc_write, reg_write, retire, trap, trap_cause;
  logic [3:0] state_dbg;
  logic [19:0] dut_outs;

  multicycle_controller #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .imm_src(imm_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .adr_src(adr_src), .mem_req(mem_req), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .retire(retire),
    .trap(trap), .trap_cause(trap_cause), .state_dbg(state_dbg)
  );

  assign dut_outs = {trap_cause, trap, retire, reg_write, pc_write, ir_write, mem_write, mem_req,
                     adr_src, result_src, alu_op, alu_src_b, alu_src_a, imm_src};

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [6:0]  op;
    logic        mr;
    logic        bt;
    logic [3:0]  st;
    logic [19:0] outv;
  } item_t;

  item_t sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      7'h03, 7'h13: return 3'b000;
      7'h23:        return 3'b001;
      7'h37, 7'h17: return 3'b010;
      7'h63:        return 3'b101;
      7'h6F:        return 3'b110;
      default:      return 3'b000;
    endcase
  endfunction

  function automatic logic [19:0] exp_out(input logic [3:0] st, input logic [6:0] op,
                                          input logic mr, input logic bt, input logic cause);
    logic [1:0] a, b, aop, rs;
    logic adr, req, mw, irw, pcw, rw, ret, tr, tc;
    a = 2'b00; b = 2'b00; aop = 2'b00; rs = 2'b00;
    {adr, req, mw, irw, pcw, rw, ret, tr, tc} = 9'b0;
    case (st)
      S_FETCH:    begin req = 1'b1; b = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
      S_DECODE:   begin a = 2'b01; b = 2'b01; end
      S_MEMADR:   begin a = 2'b10; b = 2'b01; end
      S_MEMREAD:  begin adr = 1'b1; req = 1'b1; end
      S_MEMWB:    begin rs = 2'b01; rw = 1'b1; ret = 1'b1; end
      S_MEMWRITE: begin adr = 1'b1; req = 1'b1; mw = 1'b1; ret = mr; end
      S_EXECR:    begin a = 2'b10; aop = 2'b10; end
      S_EXECI:    begin a = 2'b10; b = 2'b01; aop = 2'b10; end
      S_ALUWB:    begin rw = 1'b1; ret = 1'b1; end
      S_BRANCH:   begin a = 2'b10; aop = 2'b01; pcw = bt; ret = 1'b1; end
      S_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
      S_UTYPE:    begin a = (op == 7'h37) ? 2'b11 : 2'b01; b = 2'b01; end
      S_TRAP:     begin tr = 1'b1; tc = cause; end
      default:    a = 2'b00;
    endcase
    return {tc, tr, ret, rw, pcw, irw, mw, req, adr, rs, aop, b, a, imm_of(op)};
  endfunction

  task automatic push(input logic [6:0] op, input logic mr, input logic bt,
                      input logic [3:0] st, input logic cause);
    item_t it;
    it.op = op; it.mr = mr; it.bt = bt; it.st = st;
    it.outv = exp_out(st, op, mr, bt, cause);
    sb.push_back(it);
  endtask

  task automatic push_fetch(input logic [6:0] op, input int fwait);
    for (int i = 0; i < fwait; i++) push(op, 1'b0, rnd(), S_FETCH, 1'b0);
    push(op, 1'b1, rnd(), S_FETCH, 1'b0);
    push(op, rnd(), rnd(), S_DECODE, 1'b0);
  endtask

  task automatic push_instr(input logic [6:0] op, input logic bt, input int fwait, input int mwait);
    logic [3:0] mst;
    push_fetch(op, fwait);
    case (op)
      7'h03, 7'h23: begin
        push(op, rnd(), rnd(), S_MEMADR, 1'b0);
        mst = (op == 7'h23) ? S_MEMWRITE : S_MEMREAD;
        for (int i = 0; i < mwait; i++) push(op, 1'b0, rnd(), mst, 1'b0);
        push(op, 1'b1, rnd(), mst, 1'b0);
        if (op == 7'h03) push(op, rnd(), rnd(), S_MEMWB, 1'b0);
      end
      7'h33: begin push(op, rnd(), rnd(), S_EXECR, 1'b0); push(op, rnd(), rnd(), S_ALUWB, 1'b0); end
      7'h13: begin push(op, rnd(), rnd(), S_EXECI, 1'b0); push(op, rnd(), rnd(), S_ALUWB, 1'b0); end
      7'h63: push(op, rnd(), bt, S_BRANCH, 1'b0);
      7'h6F: begin push(op, rnd(), rnd(), S_JAL, 1'b0); push(op, rnd(), rnd(), S_ALUWB, 1'b0); end
      7'h37, 7'h17: begin push(op, rnd(), rnd(), S_UTYPE, 1'b0); push(op, rnd(), rnd(), S_ALUWB, 1'b0); end
      default: for (int i = 0; i < 20; i++) push(op, rnd(), rnd(), S_TRAP, 1'b0);
    endcase
  endtask

  task automatic run_sb();
    item_t it;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      opcode = it.op;
      mem_ready = it.mr;
      branch_taken = it.bt;
      @(negedge clk);
      check_eq($sformatf("cyc%0d_state", cyc), 32'(state_dbg), 32'(it.st));
      check_eq($sformatf("cyc%0d_outs", cyc), 32'(dut_outs), 32'(it.outv));
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset(input string tag);
    opcode = 7'h00;
    rst_n = 1'b0;
    #1;
    check_eq({tag, "_state"}, 32'(state_dbg), 32'(S_RESET));
    check_eq({tag, "_outs"}, 32'(dut_outs), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(7'h00, rnd(), rnd(), S_RESET, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("por_state", 32'(state_dbg), 32'(S_RESET));
    check_eq("por_outs", 32'(dut_outs), 32'h0);
    rst_n = 1'b1;
    push(7'h00, rnd(), rnd(), S_RESET, 1'b0);

    push_instr(7'h13, rnd(), 0, 0);
    push_instr(7'h03, rnd(), 0, 3);
    push_instr(7'h23, rnd(), 1, 2);
    push_instr(7'h33, rnd(), 0, 0);
    push_instr(7'h63, 1'b0, 0, 0);
    push_instr(7'h63, 1'b1, 0, 0);
    push_instr(7'h6F, rnd(), 0, 0);
    push_instr(7'h37, rnd(), 0, 0);
    push_instr(7'h17, rnd(), 0, 0);
    push_instr(7'h13, rnd(), TO, 0);
    push_instr(7'h03, rnd(), 0, TO);
    push_instr(7'h23, rnd(), 0, TO);
    push_instr(7'h7F, rnd(), 0, 0);
    run_sb();
    apply_reset("trap_clear");

    // abandon a load mid-wait, then confirm clean restart
    push_fetch(7'h03, 0);
    push(7'h03, rnd(), rnd(), S_MEMADR, 1'b0);
    push(7'h03, 1'b0, rnd(), S_MEMREAD, 1'b0);
    push(7'h03, 1'b0, rnd(), S_MEMREAD, 1'b0);
    run_sb();
    apply_reset("mid_instr");
    push_instr(7'h33, rnd(), 0, 0);

    for (int i = 0; i <= TO; i++) push(7'h13, 1'b0, rnd(), S_FETCH, 1'b0);
    for (int i = 0; i < 6; i++) push(7'h13, rnd(), rnd(), S_TRAP, 1'b1);
    run_sb();
    apply_reset("fetch_to");

    push_fetch(7'h03, 0);
    push(7'h03, rnd(), rnd(), S_MEMADR, 1'b0);
    for (int i = 0; i <= TO; i++) push(7'h03, 1'b0, rnd(), S_MEMREAD, 1'b0);
    for (int i = 0; i < 4; i++) push(7'h03, rnd(), rnd(), S_TRAP, 1'b1);
    run_sb();
    apply_reset("memrd_to");
    push_instr(7'h13, rnd(), 0, 0);
    run_sb();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
